// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add cell and a carry flop walk the operands LSB first,
// producing a WIDTH-bit sum plus carry-out behind a start/busy/done handshake.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             c_q, c_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;

   logic             half_s;
   logic             s_bit;
   logic             c_next;

   // Full-add cell built from two half-add levels over the current LSBs and the carry flop.
   assign half_s = a_sr_q[0] ^ b_sr_q[0];
   assign s_bit  = half_s ^ c_q;
   assign c_next = (a_sr_q[0] & b_sr_q[0]) | (c_q & half_s);

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      carry_d = carry_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               s_sr_d  = '0;
               c_d     = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
            s_sr_d = {s_bit, s_sr_q[WIDTH-1:1]};
            c_d    = c_next;
            cnt_d  = cnt_q + CNT_ONE;
            // Publish only the complete result so partial sums never reach the outputs.
            if (cnt_q == CNT_LAST) begin
               sum_d   = {s_bit, s_sr_q[WIDTH-1:1]};
               carry_d = c_next;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign sum   = sum_q;
   assign carry = carry_q;

endmodule
